fetch_stage: RTL and testbench

Instruction fetch stage of the RV32I core, directly upstream of `control`. It holds the program counter and issues one word request at a time to instruction memory. The returned instruction is held in an instruction register, and the stage slices `op_code`, `func3` and `func7` from it to drive the control unit. The PC is updated from the branch/jump decision (`pc_src`, `pc_target`) whenever the held instruction retires.

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/pc_register.sv | 30 +++
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Definitions shared by the RV32I front end: opcode constants, the NOP word and
// the fetch FSM state encoding used by both fetch_stage and control.
package rv32i_pkg;

   localparam logic [6:0]  OP_LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_STORE  = 7'b0100011;
   localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
   localparam logic [6:0]  OP_ITYPE  = 7'b0010011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with next-PC selection, PC+4 adder and a misalignment flag
// for the candidate next PC; the PC only advances on an aligned retire.
module pc_register #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        retire,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        misaligned
);

   logic [31:0] next_pc;

   assign pc_plus4   = pc + 32'd4;
   assign next_pc    = pc_src ? pc_target : pc_plus4;
   assign misaligned = |next_pc[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (retire && !misaligned) begin
         pc <= next_pc;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: one outstanding word request, an instruction register
// feeding the control unit, retire counting and a sticky misaligned-target halt.
module fetch_stage
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [6:0]  op_code,
   output logic [2:0]  func3,
   output logic [6:0]  func7,
   output logic        fault,
   output logic [31:0] instret
);

   if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
      $error("fetch_stage: RESET_PC must be word aligned");
   end

   fetch_state_t state_q, state_d;
   logic         run_q;
   logic         retire;
   logic         load_instr;
   logic         misaligned;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk        (clk),
      .rst_n      (rst_n),
      .retire     (retire),
      .pc_src     (pc_src),
      .pc_target  (pc_target),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .misaligned (misaligned)
   );

   // run_q keeps the request low until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      retire      = 1'b0;
      load_instr  = 1'b0;
      case (state_q)
         FETCH: begin
            imem_req = run_q;
            if (run_q && imem_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               load_instr = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (!stall) begin
               retire  = 1'b1;
               state_d = misaligned ? HALT : FETCH;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // rdata is only captured in WAIT, so stray rvalid in other states is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= NOP_INSTR;
      end else if (load_instr) begin
         instr <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret <= 32'd0;
      end else if (retire) begin
         instret <= instret + 32'd1;
      end
   end

   assign imem_addr = pc;
   assign fault     = (state_q == HALT);
   assign op_code   = instr[6:0];
   assign func3     = instr[14:12];
   assign func7     = instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small memory driver, a scoreboard of
// expected {pc, instr} pairs and a reference PC/instret model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        pc_src;
   logic [31:0] pc_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [6:0]  op_code;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic        fault;
   logic [31:0] instret;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .pc_src      (pc_src),
      .pc_target   (pc_target),
      .instr_valid (instr_valid),
      .instr       (instr),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .op_code     (op_code),
      .func3       (func3),
      .func7       (func7),
      .fault       (fault),
      .instret     (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          errors  = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_instret;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_req_seen"}, {31'd0, imem_req}, 32'd1);
   endtask

   // Issue one fetch; pre_wait delays ready, lat delays rvalid, both adds a stray rvalid with ready
   task automatic fetch_one(input string tag, input logic [31:0] word, input int pre_wait,
                            input int lat, input bit both);
      exp_t e;
      exp_t got;
      wait_req(tag);
      check({tag, "_addr"}, imem_addr, exp_pc);
      e.pc    = exp_pc;
      e.instr = word;
      sb.push_back(e);
      repeat (pre_wait) begin
         @(negedge clk);
         check({tag, "_req_held"}, {31'd0, imem_req}, 32'd1);
      end
      imem_ready = 1'b1;
      if (both) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      check({tag, "_wait_req"}, {31'd0, imem_req}, 32'd0);
      check({tag, "_wait_valid"}, {31'd0, instr_valid}, 32'd0);
      repeat (lat) @(negedge clk);
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check({tag, "_instr"},    instr,            got.instr);
         check({tag, "_pc"},       pc,               got.pc);
         check({tag, "_op_code"},  {25'd0, op_code}, {25'd0, got.instr[6:0]});
         check({tag, "_func3"},    {29'd0, func3},   {29'd0, got.instr[14:12]});
         check({tag, "_func7"},    {25'd0, func7},   {25'd0, got.instr[31:25]});
         check({tag, "_pc_plus4"}, pc_plus4,         got.pc + 32'd4);
      end
   endtask

   // Hold for nstall cycles (with garbage branch inputs), then retire
   task automatic retire_one(input string tag, input int nstall, input logic src,
                             input logic [31:0] target);
      logic [31:0] held;
      logic [31:0] nxt;
      held = instr;
      repeat (nstall) begin
         stall     = 1'b1;
         pc_src    = 1'b1;
         pc_target = 32'h0000_0003;
         @(negedge clk);
         check({tag, "_stall_instr"},   instr,   held);
         check({tag, "_stall_pc"},      pc,      exp_pc);
         check({tag, "_stall_instret"}, instret, exp_instret);
         check({tag, "_stall_req"},     {31'd0, imem_req}, 32'd0);
      end
      stall     = 1'b0;
      pc_src    = src;
      pc_target = target;
      @(negedge clk);
      stall     = 1'b1;
      pc_src    = 1'b0;
      pc_target = 32'h0;
      exp_instret = exp_instret + 32'd1;
      nxt = src ? target : exp_pc + 32'd4;
      check({tag, "_instret"}, instret, exp_instret);
      if (nxt[1:0] != 2'b00) begin
         check({tag, "_fault"}, {31'd0, fault}, 32'd1);
         check({tag, "_halt_req"}, {31'd0, imem_req}, 32'd0);
         check({tag, "_halt_valid"}, {31'd0, instr_valid}, 32'd0);
         check({tag, "_halt_pc"}, pc, exp_pc);
      end else begin
         exp_pc = nxt;
         check({tag, "_next_req"}, {31'd0, imem_req}, 32'd1);
         check({tag, "_next_addr"}, imem_addr, exp_pc);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pc"},      pc,               32'h0);
      check({tag, "_instr"},   instr,            32'h0000_0013);
      check({tag, "_op_code"}, {25'd0, op_code}, 32'h13);
      check({tag, "_func3"},   {29'd0, func3},   32'd0);
      check({tag, "_func7"},   {25'd0, func7},   32'd0);
      check({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
      check({tag, "_fault"},   {31'd0, fault},   32'd0);
      check({tag, "_instret"}, instret,          32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      stall       = 1'b1;
      pc_src      = 1'b0;
      pc_target   = 32'h0;
      exp_pc      = 32'h0;
      exp_instret = 32'h0;

      // Reset and first fetch
      repeat (3) @(negedge clk);
      check("rst_req_low", {31'd0, imem_req}, 32'd0);
      check_reset_state("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_addr", imem_addr, 32'h0);
      check_reset_state("first");

      // Load decode handoff
      fetch_one("lw", 32'h0000_2083, 0, 0, 1'b0);
      check("lw_opcode_const", {25'd0, op_code}, 32'h03);
      check("lw_func3_const", {29'd0, func3}, 32'd2);
      retire_one("lw_ret", 0, 1'b0, 32'h0);

      // Delayed ready, stray rvalid alongside ready, slow memory, 4-cycle stall
      fetch_one("add", 32'h0020_81B3, 2, 2, 1'b1);
      retire_one("add_ret", 4, 1'b0, 32'h0);

      // Branch redirect from pc=8
      fetch_one("sub", 32'h4073_02B3, 0, 0, 1'b0);
      check("sub_func7_const", {25'd0, func7}, 32'h20);
      retire_one("br_ret", 0, 1'b1, 32'h0000_0040);

      // Instruction at target, then misaligned redirect
      fetch_one("addi", 32'h00A0_0093, 0, 1, 1'b0);
      check("addi_pc_plus4", pc_plus4, 32'h0000_0044);
      retire_one("mis_ret", 1, 1'b1, 32'h0000_0042);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      imem_ready  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("halt_req", {31'd0, imem_req}, 32'd0);
         check("halt_fault", {31'd0, fault}, 32'd1);
         check("halt_pc", pc, 32'h0000_0040);
         check("halt_instr", instr, 32'h00A0_0093);
      end
      imem_rvalid = 1'b0;
      imem_ready  = 1'b0;
      imem_rdata  = 32'h0;

      // Reset pulse clears the fault
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_state("clr");
      rst_n = 1'b1;
      exp_pc = 32'h0;
      exp_instret = 32'h0;
      @(negedge clk);
      check("clr_req", {31'd0, imem_req}, 32'd1);
      check("clr_addr", imem_addr, 32'h0);

      // Reset while WAIT, then stale rvalid in FETCH
      imem_ready = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      check("rw_in_wait", {31'd0, imem_req}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("rw_rst_req", {31'd0, imem_req}, 32'd0);
      check_reset_state("rw_rst");
      @(negedge clk);
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      check("stale_instr", instr, 32'h0000_0013);
      check("stale_valid", {31'd0, instr_valid}, 32'd0);
      check("stale_req", {31'd0, imem_req}, 32'd1);
      check("stale_addr", imem_addr, 32'h0);

      // Normal operation resumes from RESET_PC
      fetch_one("post", 32'h0000_2083, 0, 0, 1'b0);
      retire_one("post_ret", 0, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
